// File: rtl/axil_cfg_arbiter.sv
// Two-requester round-robin front end for a single AXI4-Lite master port.
// One single-beat read or write is latched per grant. The block drives the
// AW/W/B or AR/R handshakes, then returns data and response to the winner
// with a one-cycle done pulse. Every output comes straight from a flop.
module axil_cfg_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                rq0_valid,
    input  logic                rq0_write,
    input  logic [ADDR_W-1:0]   rq0_addr,
    input  logic [DATA_W-1:0]   rq0_wdata,
    output logic                rq0_done,
    output logic [DATA_W-1:0]   rq0_rdata,
    output logic [1:0]          rq0_resp,
    input  logic                rq1_valid,
    input  logic                rq1_write,
    input  logic [ADDR_W-1:0]   rq1_addr,
    input  logic [DATA_W-1:0]   rq1_wdata,
    output logic                rq1_done,
    output logic [DATA_W-1:0]   rq1_rdata,
    output logic [1:0]          rq1_resp,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [2:0]          M_AXI_AWPROT,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [2:0]          M_AXI_ARPROT,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY,
    output logic                busy
);
    typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                arvalid_q, arvalid_d, rready_q, rready_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [1:0]          resp0_q, resp0_d, resp1_q, resp1_d;
    logic                done0_q, done0_d, done1_q, done1_d;
    logic                busy_q, busy_d;
    logic                arb_sel, arb_write;

    // Round-robin pick: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        arb_sel = rq1_valid;
        if (rq0_valid && rq1_valid) arb_sel = ~last_gnt_q;
        arb_write = arb_sel ? rq1_write : rq0_write;
    end

    // Transaction sequencer: next state plus next value of every registered output
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        resp0_d    = resp0_q;
        resp1_d    = resp1_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rq0_valid || rq1_valid) begin
                    gnt_d      = arb_sel;
                    last_gnt_d = arb_sel;
                    addr_d     = arb_sel ? rq1_addr  : rq0_addr;
                    wdata_d    = arb_sel ? rq1_wdata : rq0_wdata;
                    if (arb_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RADDR;
                    end
                end
            end
            WR: begin
                // AW and W retire independently, in either order
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (bready_q && M_AXI_BVALID) begin
                    bready_d = 1'b0;
                    state_d  = DONE;
                    if (gnt_q) begin
                        rdata1_d = '0;
                        resp1_d  = M_AXI_BRESP;
                        done1_d  = 1'b1;
                    end else begin
                        rdata0_d = '0;
                        resp0_d  = M_AXI_BRESP;
                        done0_d  = 1'b1;
                    end
                end
            end
            RADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (rready_q && M_AXI_RVALID) begin
                    rready_d = 1'b0;
                    state_d  = DONE;
                    if (gnt_q) begin
                        rdata1_d = M_AXI_RDATA;
                        resp1_d  = M_AXI_RRESP;
                        done1_d  = 1'b1;
                    end else begin
                        rdata0_d = M_AXI_RDATA;
                        resp0_d  = M_AXI_RRESP;
                        done0_d  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight AXI transfer
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            resp0_q    <= '0;
            resp1_q    <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            resp0_q    <= resp0_d;
            resp1_q    <= resp1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
        end
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign rq0_done      = done0_q;
    assign rq1_done      = done1_q;
    assign rq0_rdata     = rdata0_q;
    assign rq1_rdata     = rdata1_q;
    assign rq0_resp      = resp0_q;
    assign rq1_resp      = resp1_q;
    assign busy          = busy_q;
endmodule
